// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro ALU_DIV_ZERO_TRAP_EN: a zero divisor finishes at once and raises div_zero.
module alu_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | one restoring step per cycle, cnt counts down N..1
  // DONE  | results valid, done pulse; a start here begins the next operation
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t         state, state_nx;
  logic [N:0]     r_q, r_nx;
  logic [N-1:0]   q_q, q_nx;
  logic [N-1:0]   d_q, d_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [N-1:0]   quo_nx, rem_nx;
  logic [N:0]     r_shift;
  logic [N+1:0]   sum;
  logic           carry;

  // The partial remainder never exceeds the divisor, so its top bit is shifted out unread.
  logic unused_r_msb;
  assign unused_r_msb = r_q[N];

  // Same arithmetic as the ALU subtract path: carry-out set means no borrow.
  assign r_shift = {r_q[N-1:0], q_q[N-1]};
  assign sum     = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + {{(N+1){1'b0}}, 1'b1};
  assign carry   = sum[N+1];

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef ALU_DIV_ZERO_TRAP_EN
  logic dz_nx;
`endif

  always_comb begin
    state_nx = state;
    r_nx     = r_q;
    q_nx     = q_q;
    d_nx     = d_q;
    cnt_nx   = cnt;
    quo_nx   = quotient;
    rem_nx   = remainder;
`ifdef ALU_DIV_ZERO_TRAP_EN
    dz_nx    = div_zero;
`endif
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          r_nx     = '0;
          q_nx     = dividend;
          d_nx     = divisor;
          cnt_nx   = CNT_INIT;
          state_nx = RUN;
`ifdef ALU_DIV_ZERO_TRAP_EN
          dz_nx = 1'b0;
          if (divisor == '0) begin
            state_nx = DONE;
            quo_nx   = '1;
            rem_nx   = dividend;
            dz_nx    = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        if (carry) begin
          r_nx = sum[N:0];
          q_nx = {q_q[N-2:0], 1'b1};
        end else begin
          r_nx = r_shift;
          q_nx = {q_q[N-2:0], 1'b0};
        end
        cnt_nx = cnt - CNT_LAST;
        if (cnt == CNT_LAST) begin
          state_nx = DONE;
          quo_nx   = q_nx;
          rem_nx   = r_nx[N-1:0];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nx;
      r_q       <= r_nx;
      q_q       <= q_nx;
      d_q       <= d_nx;
      cnt       <= cnt_nx;
      quotient  <= quo_nx;
      remainder <= rem_nx;
    end
  end

`ifdef ALU_DIV_ZERO_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) div_zero <= 1'b0;
    else        div_zero <= dz_nx;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: vector table, handshake corner cases, random back-to-back stream.
module tb_alu_divider;
  localparam int N = 8;
`ifdef ALU_DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int failures = 0;
  logic [7:0] last_q = 8'd0;
  logic [7:0] last_r = 8'd0;

  always #5 clk = ~clk;

  alu_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r);
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge of the done cycle with start low.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er);
    int lat = 0;
    int nbusy = 0;
    bit seen = 1'b0;
    bit ez;
    int elat;
    ez   = TRAP && (b == 8'd0);
    elat = ez ? 1 : N + 1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (!seen && lat < 3 * N) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        chk({tag, " hold_quotient"}, quotient, last_q);
        chk({tag, " hold_remainder"}, remainder, last_r);
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy_cycles"}, nbusy, elat - 1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_zero"}, div_zero, ez);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    logic [7:0] a, b, eq, er;
    int ndone;
    int dlat;

    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2};
    vecs[1]  = '{8'd3,   8'd2,   8'd1,   8'd1};
    vecs[2]  = '{8'd255, 8'd1,   8'd255, 8'd0};
    vecs[3]  = '{8'd5,   8'd9,   8'd0,   8'd5};
    vecs[4]  = '{8'd42,  8'd0,   8'd255, 8'd42};
    vecs[5]  = '{8'd0,   8'd1,   8'd0,   8'd0};
    vecs[6]  = '{8'd0,   8'd255, 8'd0,   8'd0};
    vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0};
    vecs[8]  = '{8'd254, 8'd255, 8'd0,   8'd254};
    vecs[9]  = '{8'd128, 8'd2,   8'd64,  8'd0};
    vecs[10] = '{8'd1,   8'd0,   8'd255, 8'd1};
    vecs[11] = '{8'd200, 8'd10,  8'd20,  8'd0};

    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_zero", div_zero, 0);
    start = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    chk("reset over start busy", busy, 0);
    chk("reset over start done", done, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_op("vec", vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      @(negedge clk);
      chk("vec done_pulse_width", done, 0);
    end

    // Back-to-back: each next request is presented in the done cycle.
    do_op("b2b", 8'd3, 8'd2, 8'd1, 8'd1);
    do_op("b2b", 8'd255, 8'd1, 8'd255, 8'd0);
    do_op("b2b", 8'd5, 8'd9, 8'd0, 8'd5);
    @(negedge clk);
    chk("b2b done_pulse_width", done, 0);

    // A second start while busy must be ignored.
    dividend = 8'd200;
    divisor  = 8'd10;
    start    = 1'b1;
    ndone = 0;
    dlat  = 0;
    for (int c = 1; c <= 3 * N; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (done) begin
        ndone++;
        dlat = c;
      end
    end
    chk("ignore done_count", ndone, 1);
    chk("ignore latency", dlat, N + 1);
    chk("ignore quotient", quotient, 20);
    chk("ignore remainder", remainder, 0);
    chk("ignore busy_after", busy, 0);
    last_q = 8'd20;
    last_r = 8'd0;

    // Reset in the middle of a run aborts it without a done pulse.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    last_q = 8'd0;
    last_r = 8'd0;
    do_op("after_abort", 8'd9, 8'd3, 8'd3, 8'd0);
    @(negedge clk);

    // Random back-to-back stream against the arithmetic reference.
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom_range(255, 0));
      if (i % 64 == 0)     b = 8'd0;
      else if (i % 3 == 0) b = 8'($urandom_range(8, 1));
      else                 b = 8'($urandom_range(255, 0));
      ref_div(a, b, eq, er);
      do_op("rand", a, b, eq, er);
    end
    @(negedge clk);
    chk("rand done_pulse_width", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
